div_share_arb: RTL and testbench

Round-robin arbiter that shares one pipelined 64-bit divider between up to N requesters in the phase-adjust path, such as the phase-step and normalised frequency-add computations of several channels. It accepts at most one division per clock, tags it with the requester index, and returns quotient, remainder and divide-by-zero flag to that requester after a fixed latency. It sits between the per-channel phase-adjust controllers and the single divider resource.

---
 rtl/phase_adj_pkg.sv | 32 +++
 rtl/div_pipe.sv | 66 ++++++
 rtl/div_share_arb.sv | 132 +++++++++++++
 tb/tb_div_share_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_adj_pkg.sv
// Shared types and defaults for the phase-adjust divider sharing path.
package phase_adj_pkg;

    localparam int DIV_W_DEF   = 64;
    localparam int DIV_LAT_DEF = 2;
    localparam int N_REQ_MAX   = 8;
    localparam int TAG_IDX_W   = $clog2(N_REQ_MAX);

    typedef struct packed {
        logic [DIV_W_DEF-1:0] numer;
        logic [DIV_W_DEF-1:0] denom;
    } div_req_t;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] quot;
        logic [DIV_W_DEF-1:0] rem;
        logic                 dbz;
    } div_rsp_t;

    // Tag riding alongside each division; idx is sized for the largest
    // supported requester count so the type is independent of N_REQ.
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } div_tag_t;

    // Next round-robin position after index i among n requesters.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/div_pipe.sv
// Behavioural pipelined unsigned divider. Operands are captured on in_valid;
// the result appears DIV_LAT clocks after the capture edge. Divide-by-zero
// yields quot = all-ones, rem = numer, dbz = 1. Swappable for vendor IP.
module div_pipe
    import phase_adj_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DIV_W-1:0] numer,
    input  logic [DIV_W-1:0] denom,
    output logic [DIV_W-1:0] quot,
    output logic [DIV_W-1:0] rem,
    output logic             dbz
);

    logic [DIV_W-1:0] num_q, den_q;
    logic [DIV_W-1:0] quot_c, rem_c;
    logic             dbz_c;

    logic [DIV_LAT-1:0][DIV_W-1:0] quot_q, rem_q;
    logic [DIV_LAT-1:0]            dbz_q;

    // Divide the captured operands, applying the divide-by-zero rule.
    always_comb begin
        dbz_c  = (den_q == '0);
        quot_c = '1;
        rem_c  = num_q;
        if (!dbz_c) begin
            quot_c = num_q / den_q;
            rem_c  = num_q % den_q;
        end
    end

    // Operand capture stage followed by DIV_LAT result stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= '0;
        end else begin
            if (in_valid) begin
                num_q <= numer;
                den_q <= denom;
            end
            quot_q[0] <= quot_c;
            rem_q[0]  <= rem_c;
            dbz_q[0]  <= dbz_c;
            for (int k = 1; k < DIV_LAT; k++) begin
                quot_q[k] <= quot_q[k-1];
                rem_q[k]  <= rem_q[k-1];
                dbz_q[k]  <= dbz_q[k-1];
            end
        end
    end

    assign quot = quot_q[DIV_LAT-1];
    assign rem  = rem_q[DIV_LAT-1];
    assign dbz  = dbz_q[DIV_LAT-1];

endmodule

// File: rtl/div_share_arb.sv
// Round-robin sharing of one pipelined divider among N_REQ requesters.
// One accept per clock; a tag shift register aligned with the divider data
// routes each registered result back to its requester.
module div_share_arb
    import phase_adj_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][DIV_W-1:0] req_numer,
    input  logic [N_REQ-1:0][DIV_W-1:0] req_denom,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DIV_W-1:0]            rsp_quot,
    output logic [DIV_W-1:0]            rsp_rem,
    output logic                        rsp_dbz,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gidx, cand;
    logic             accept;

    div_tag_t [DIV_LAT:0] tag_q, tag_d;

    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DIV_W-1:0] rsp_quot_q, rsp_rem_q;
    logic             rsp_dbz_q;
    logic             rsp_fire;

    logic [DIV_W-1:0] pipe_quot, pipe_rem;
    logic             pipe_dbz;

    // Pick the first valid requester at or after rr_ptr; flush blocks accepts.
    always_comb begin
        accept = 1'b0;
        gidx   = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!accept && req_valid[cand]) begin
                accept = 1'b1;
                gidx   = cand;
            end
        end
        if (flush) accept = 1'b0;
    end

    // One-hot grant and pointer advance past the granted requester.
    always_comb begin
        req_ready = '0;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            req_ready[gidx] = 1'b1;
            rr_ptr_d        = IDX_W'(wrap_inc(int'(gidx), N_REQ));
        end
    end

    // Tag shift register; stage 0 lines up with the divider operand stage.
    always_comb begin
        tag_d          = '0;
        tag_d[0].valid = accept;
        tag_d[0].idx   = TAG_IDX_W'(gidx);
        for (int k = 1; k <= DIV_LAT; k++) tag_d[k] = tag_q[k-1];
        if (flush) begin
            for (int k = 0; k <= DIV_LAT; k++) tag_d[k].valid = 1'b0;
        end
    end

    // Decode the tag leaving the pipe into a per-requester strobe.
    always_comb begin
        rsp_fire    = tag_q[DIV_LAT].valid & ~flush;
        rsp_valid_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rsp_fire && tag_q[DIV_LAT].idx == TAG_IDX_W'(i)) rsp_valid_d[i] = 1'b1;
        end
    end

    // Busy while any tag is still inside the divider.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= DIV_LAT; k++) busy = busy | tag_q[k].valid;
    end

    div_pipe #(
        .DIV_W   (DIV_W),
        .DIV_LAT (DIV_LAT)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .in_valid (accept),
        .numer    (req_numer[gidx]),
        .denom    (req_denom[gidx]),
        .quot     (pipe_quot),
        .rem      (pipe_rem),
        .dbz      (pipe_dbz)
    );

    // Pointer, tags and result registers; result data holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            if (rsp_fire) begin
                rsp_quot_q <= pipe_quot;
                rsp_rem_q  <= pipe_rem;
                rsp_dbz_q  <= pipe_dbz;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_quot  = rsp_quot_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_dbz   = rsp_dbz_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Randomised scoreboard bench for div_share_arb with a reference model.
module tb_div_share_arb;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LAT = 2;
    localparam int IW  = $clog2(N);

    logic                clk = 1'b0;
    logic                reset, flush;
    logic [N-1:0]        req_valid, req_ready, rsp_valid;
    logic [N-1:0][W-1:0] req_numer, req_denom;
    logic [W-1:0]        rsp_quot, rsp_rem;
    logic                rsp_dbz, busy;

    always #5 clk = ~clk;

    div_share_arb #(.N_REQ(N), .DIV_W(W), .DIV_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_numer (req_numer),
        .req_denom (req_denom),
        .rsp_valid (rsp_valid),
        .rsp_quot  (rsp_quot),
        .rsp_rem   (rsp_rem),
        .rsp_dbz   (rsp_dbz),
        .busy      (busy)
    );

    typedef struct {
        int         idx;
        int         due;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ptr    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: round-robin choice from the driven valids, then plain
    // arithmetic for the expected result, due LAT+2 negedges later.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            sb.delete();
            ptr = 0;
        end else begin
            int           g;
            logic [IW-1:0] c, gi;
            logic [N-1:0] eg;
            exp_t         e;
            g  = -1;
            eg = '0;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    c = IW'((ptr + k) % N);
                    if (g < 0 && req_valid[c]) g = int'(c);
                end
            end
            gi = IW'(g < 0 ? 0 : g);
            if (g >= 0) eg[gi] = 1'b1;
            chk("req_ready", W'(req_ready), W'(eg));
            if (flush) begin
                while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            end
            if (g >= 0) begin
                e.idx = g;
                e.due = cyc + LAT + 2;
                if (req_denom[gi] == '0) begin
                    e.q = '1;
                    e.r = req_numer[gi];
                    e.z = 1'b1;
                end else begin
                    e.q = req_numer[gi] / req_denom[gi];
                    e.r = req_numer[gi] % req_denom[gi];
                    e.z = 1'b0;
                end
                sb.push_back(e);
                ptr = (g + 1) % N;
            end
        end
    end

    // Monitor: pop and compare whenever a response is due; check busy.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t         e;
            logic [N-1:0] ev;
            logic         bexp;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("rsp_late", W'(cyc), W'(e.due));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e  = sb.pop_front();
                ev = '0;
                ev[IW'(e.idx)] = 1'b1;
                chk("rsp_valid", W'(rsp_valid), W'(ev));
                chk("rsp_quot", rsp_quot, e.q);
                chk("rsp_rem", rsp_rem, e.r);
                chk("rsp_dbz", W'(rsp_dbz), W'(e.z));
            end else begin
                chk("rsp_idle", W'(rsp_valid), '0);
            end
            bexp = 1'b0;
            foreach (sb[i]) if (sb[i].due <= cyc + LAT + 1) bexp = 1'b1;
            chk("busy", W'(busy), W'(bexp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, W'(rsp_valid), '0);
        chk({tag, "_rsp_quot"}, rsp_quot, '0);
        chk({tag, "_rsp_rem"}, rsp_rem, '0);
        chk({tag, "_rsp_dbz"}, W'(rsp_dbz), '0);
        chk({tag, "_busy"}, W'(busy), '0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_numer = '0;
        req_denom = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;
        step();

        // single division 100/7 from requester 0
        req_numer[0] = 64'd100; req_denom[0] = 64'd7;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (5) step();

        // contention: everyone asks for 8 cycles, idx*1000/3
        for (int i = 0; i < N; i++) begin
            req_numer[i] = W'(i * 1000);
            req_denom[i] = 64'd3;
        end
        req_valid = 4'hF;
        repeat (8) step();
        req_valid = '0;
        repeat (5) step();

        // divide by zero from requester 2
        req_numer[2] = 64'd5; req_denom[2] = '0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (5) step();

        // flush with two in flight and requester 1 waiting
        req_numer[0] = 64'd50; req_denom[0] = 64'd5;
        req_numer[1] = 64'd77; req_denom[1] = 64'd4;
        req_valid = 4'b0001; step();
        req_valid = 4'b0010; step();
        flush = 1'b1;        step();
        flush = 1'b0;        step();
        req_valid = '0;
        repeat (6) step();

        // reset with three in flight, then a fresh division
        req_valid = 4'hF;
        repeat (3) step();
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk_reset_state("midreset");
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            req_numer[i] = 64'h0147_AE14 * 64'd50;
            req_denom[i] = 64'd10000;
        end
        req_valid = 4'hF;
        step();
        req_valid = '0;
        repeat (6) step();

        // back-to-back from requester 3
        req_valid = 4'b1000;
        for (int j = 1; j <= 10; j++) begin
            req_numer[3] = 64'(j) * 64'h4000_0000;
            req_denom[3] = 64'd10000;
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // randomised traffic with occasional flushes
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                req_numer[i] = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0: req_denom[i] = '0;
                    1: req_denom[i] = W'($urandom_range(1, 20));
                    2: req_denom[i] = {$urandom, $urandom};
                    default: req_denom[i] = {32'h0, $urandom};
                endcase
            end
            req_valid = N'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush     = 1'b0;
        req_valid = '0;
        repeat (8) step();

        chk("drain", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
